// File: rtl/audio_capture_pkg.sv
// Shared constants for the multi-lane I2S capture engine: register map,
// control/status bit positions, RAM window and capture FSM encoding.
package audio_capture_pkg;

  localparam logic [15:0] REG_CONTROL = 16'h0000;
  localparam logic [15:0] REG_STATUS  = 16'h0004;
  localparam logic [15:0] REG_FRAME   = 16'h0008;
  localparam logic [15:0] RAM_BASE    = 16'h8000;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_FREEZE  = 1;
  localparam int CTRL_ONESHOT = 2;

  localparam int STAT_FROZEN  = 0;
  localparam int STAT_OVERRUN = 1;
  localparam int STAT_WRAPPED = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  localparam logic [5:0] POSN_LAST = 6'd63;

endpackage

// File: rtl/audio_capture_i2s_lane_rx.sv
// Per-lane I2S deserialiser. Bits shift in MSB first with the one-bit I2S
// delay. left/right present the value *after* the current bit-clock enable so
// the frame-end latch also catches a bit arriving at position 63.
module i2s_lane_rx #(
  parameter int SAMPLE_W = 16
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                i2s_en,
  input  logic [5:0]          frame_posn,
  input  logic                sd,
  output logic [SAMPLE_W-1:0] left,
  output logic [SAMPLE_W-1:0] right
);

  localparam logic [5:0] L_FIRST = 6'd1;
  localparam logic [5:0] L_LAST  = 6'(SAMPLE_W);
  localparam logic [5:0] R_FIRST = 6'd33;
  localparam logic [5:0] R_LAST  = 6'(32 + SAMPLE_W);

  logic [SAMPLE_W-1:0] left_q;
  logic [SAMPLE_W-1:0] right_q;

  // Next-value shift logic for the left and right sample windows
  always_comb begin
    left  = left_q;
    right = right_q;
    if (i2s_en) begin
      if (frame_posn >= L_FIRST && frame_posn <= L_LAST)
        left = SAMPLE_W'({left_q, sd});
      if (frame_posn >= R_FIRST && frame_posn <= R_LAST)
        right = SAMPLE_W'({right_q, sd});
    end
  end

  // Shift registers
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      left_q  <= '0;
      right_q <= '0;
    end else begin
      left_q  <= left;
      right_q <= right;
    end
  end

endmodule

// File: rtl/dpram.sv
// Simple dual-port RAM: one synchronous write port, one read port with
// one cycle of read latency. Contents are not reset.
module dpram #(
  parameter int BITS = 16,
  parameter int SIZE = 256,
  localparam int AW = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [BITS-1:0] rdata
);

  logic [BITS-1:0] mem [SIZE];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_capture.sv
// Multi-lane I2S capture engine. Deserialises LANES stereo lanes, writes each
// frame as a burst of CHANNELS words into a circular RAM indexed
// {channel, frame}, and exposes RAM and control/status over the iomem bus.
//
// Bus handshake: a request is taken when iomem_valid is high, the page
// matches and no transaction is in flight. iomem_ready then pulses for exactly
// one cycle (one cycle after acceptance for registers, two for RAM reads),
// with iomem_rdata valid only while iomem_ready is high. No further ready is
// produced until iomem_valid has been dropped.
module audio_capture
  import audio_capture_pkg::*;
#(
  parameter logic [15:0] ADDR     = 16'h6000,
  parameter int          LANES    = 4,
  parameter int          SAMPLE_W = 16,
  parameter int          FRAMES   = 256,
  localparam int         FRAME_W  = $clog2(FRAMES)
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               i2s_en,
  input  logic [5:0]         frame_posn,
  input  logic [LANES-1:0]   sd_in,
  input  logic               iomem_valid,
  input  logic [3:0]         iomem_wstrb,
  input  logic [31:0]        iomem_addr,
  input  logic [31:0]        iomem_wdata,
  output logic               iomem_ready,
  output logic [31:0]        iomem_rdata,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_strobe,
  output logic               overrun,
  output logic               capture_state
);

  localparam int CHANNELS = 2 * LANES;
  localparam int CHAN_W   = $clog2(CHANNELS);
  localparam int IDX_W    = CHAN_W + FRAME_W;
  localparam int RAM_SIZE = CHANNELS * FRAMES;

  logic [SAMPLE_W-1:0] lane_left  [LANES];
  logic [SAMPLE_W-1:0] lane_right [LANES];
  logic [SAMPLE_W-1:0] hold [CHANNELS];
  logic [SAMPLE_W-1:0] ram_q;

  logic [0:0]         state;
  logic [CHAN_W-1:0]  chan;
  logic [FRAME_W-1:0] wr_frame;
  logic [FRAME_W-1:0] wr_next;
  logic [2:0]         ctrl;
  logic               frozen;
  logic               wrapped;
  logic               busy;
  logic               ram_pend;

  logic        frame_end, start, last_chan, wrap_evt, overrun_evt;
  logic        bus_sel, is_write, is_ram;
  logic        wr_ctrl, wr_stat, wr_frame_reg;
  logic [15:0] off;
  logic [31:0] ram_off;
  logic [31:0] reg_rd;
  logic        unused_bits;

  assign capture_state = state;
  assign unused_bits   = ^{iomem_wdata, iomem_addr[1:0]};

  genvar n;
  generate
    for (n = 0; n < LANES; n++) begin : g_lane
      i2s_lane_rx #(.SAMPLE_W(SAMPLE_W)) u_lane (
        .ck         (ck),
        .rst        (rst),
        .i2s_en     (i2s_en),
        .frame_posn (frame_posn),
        .sd         (sd_in[n]),
        .left       (lane_left[n]),
        .right      (lane_right[n])
      );
    end
  endgenerate

  dpram #(.BITS(SAMPLE_W), .SIZE(RAM_SIZE)) u_ram (
    .clk   (ck),
    .we    (state == ST_WRITE),
    .waddr ({chan, wr_frame}),
    .wdata (hold[chan]),
    .raddr (ram_off[IDX_W-1:0]),
    .rdata (ram_q)
  );

  // Capture events and bus decode
  always_comb begin
    frame_end    = i2s_en && (frame_posn == POSN_LAST);
    start        = (state == ST_IDLE) && frame_end && ctrl[CTRL_ENABLE] && !frozen;
    last_chan    = (state == ST_WRITE) && (chan == CHAN_W'(CHANNELS - 1));
    wr_next      = wr_frame + FRAME_W'(1);
    wrap_evt     = last_chan && (wr_next == '0);
    overrun_evt  = (state == ST_WRITE) && frame_end;
    off          = iomem_addr[15:0];
    ram_off      = 32'(iomem_addr[14:2]);
    bus_sel      = iomem_valid && (iomem_addr[31:16] == ADDR) && !busy;
    is_write     = |iomem_wstrb;
    is_ram       = (off >= RAM_BASE) && (ram_off < 32'(RAM_SIZE));
    wr_ctrl      = bus_sel && is_write && (off == REG_CONTROL);
    wr_stat      = bus_sel && is_write && (off == REG_STATUS);
    wr_frame_reg = bus_sel && is_write && (off == REG_FRAME);
    reg_rd       = '0;
    case (off)
      REG_CONTROL: reg_rd = {29'd0, ctrl};
      REG_STATUS:  reg_rd = {29'd0, wrapped, overrun, frozen};
      REG_FRAME:   reg_rd = 32'(wr_frame);
      default:     reg_rd = '0;
    endcase
  end

  // Bus acknowledge and read data; RAM reads take one extra cycle
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      busy        <= 1'b0;
      ram_pend    <= 1'b0;
    end else begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      ram_pend    <= 1'b0;
      if (!iomem_valid) busy <= 1'b0;
      else if (bus_sel) busy <= 1'b1;
      if (ram_pend) begin
        iomem_ready <= 1'b1;
        iomem_rdata <= 32'(ram_q);
      end else if (bus_sel) begin
        if (!is_write && is_ram) begin
          ram_pend <= 1'b1;
        end else begin
          iomem_ready <= 1'b1;
          iomem_rdata <= is_write ? 32'd0 : reg_rd;
        end
      end
    end
  end

  // Capture FSM: latch lanes on frame end, then write one channel per cycle
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      chan         <= '0;
      wr_frame     <= '0;
      frame        <= '0;
      frame_strobe <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) hold[i] <= '0;
    end else begin
      frame_strobe <= 1'b0;
      if (wr_frame_reg && !ctrl[CTRL_ENABLE]) wr_frame <= iomem_wdata[FRAME_W-1:0];
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < LANES; i++) begin
              hold[2*i]   <= lane_left[i];
              hold[2*i+1] <= lane_right[i];
            end
            chan  <= '0;
            state <= ST_WRITE;
          end
        end
        default: begin
          if (last_chan) begin
            frame        <= wr_frame;
            wr_frame     <= wr_next;
            frame_strobe <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            chan <= chan + CHAN_W'(1);
          end
        end
      endcase
    end
  end

  // Control register and status flags; a set event beats a same-cycle W1C
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      ctrl    <= '0;
      frozen  <= 1'b0;
      overrun <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= iomem_wdata[2:0];
      if (wr_stat && iomem_wdata[STAT_OVERRUN]) overrun <= 1'b0;
      if (overrun_evt) overrun <= 1'b1;
      if (wr_stat && iomem_wdata[STAT_WRAPPED]) wrapped <= 1'b0;
      if (wrap_evt) wrapped <= 1'b1;
      if (last_chan) begin
        if (ctrl[CTRL_FREEZE] || (wrap_evt && ctrl[CTRL_ONESHOT])) frozen <= 1'b1;
      end else if (state == ST_IDLE) begin
        if (ctrl[CTRL_FREEZE]) frozen <= 1'b1;
        else if (!ctrl[CTRL_ONESHOT]) frozen <= 1'b0;
      end
    end
  end

endmodule
